// File: rtl/branch_unit.sv
// Program sequencer: PC, flag-conditioned jumps, and CALL/RET via a small
// hardware return-address stack with sticky overflow/underflow reporting.
module branch_unit #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           br_rst_n,
  input  logic                           br_en,
  input  logic [2:0]                     br_op,
  input  logic [ADDR_W-1:0]              br_target,
  input  logic                           br_flag_c,
  input  logic                           br_flag_z,
  input  logic                           br_flag_b,
  output logic [ADDR_W-1:0]              br_pc,
  output logic                           br_taken,
  output logic [$clog2(STACK_DEPTH):0]   br_sp,
  output logic                           br_err
);

  localparam int SW = $clog2(STACK_DEPTH) + 1;
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SW-1:0] SP_FULL = SW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_JMP  = 3'b001,
    OP_JZ   = 3'b010,
    OP_JNZ  = 3'b011,
    OP_JC   = 3'b100,
    OP_JB   = 3'b101,
    OP_CALL = 3'b110,
    OP_RET  = 3'b111
  } op_e;

  op_e               op;
  logic              jump_cond;
  logic              stack_full;
  logic              stack_empty;
  logic [ADDR_W-1:0] pc_inc;
  logic [IW-1:0]     push_idx;
  logic [IW-1:0]     pop_idx;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  assign op          = op_e'(br_op);
  assign pc_inc      = br_pc + ADDR_W'(1);
  assign stack_full  = (br_sp == SP_FULL);
  assign stack_empty = (br_sp == '0);
  assign push_idx    = IW'(br_sp);
  assign pop_idx     = IW'(br_sp - SW'(1));

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    jump_cond = 1'b0;
    unique case (op)
      OP_JMP:  jump_cond = 1'b1;
      OP_JZ:   jump_cond = br_flag_z;
      OP_JNZ:  jump_cond = ~br_flag_z;
      OP_JC:   jump_cond = br_flag_c;
      OP_JB:   jump_cond = br_flag_b;
      default: jump_cond = 1'b0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge br_rst_n) begin
    if (!br_rst_n) begin
      br_pc    <= '0;
      br_sp    <= '0;
      br_taken <= 1'b0;
      br_err   <= 1'b0;
      // NOTE: the stack is small and must read as zero after reset, so it is reset explicitly.
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (!br_en) begin
      br_taken <= 1'b0;
    end else begin
      br_pc    <= pc_inc;
      br_taken <= 1'b0;
      unique case (op)
        OP_CALL: begin
          if (stack_full) begin
            br_err <= 1'b1;
          end else begin
            stack[push_idx] <= pc_inc;
            br_sp           <= br_sp + SW'(1);
            br_pc           <= br_target;
            br_taken        <= 1'b1;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            br_err <= 1'b1;
          end else begin
            br_pc    <= stack[pop_idx];
            br_sp    <= br_sp - SW'(1);
            br_taken <= 1'b1;
          end
        end
        default: begin
          if (jump_cond) begin
            br_pc    <= br_target;
            br_taken <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a behavioral model pushes expected state
// per driven cycle; entries are popped and compared one clock later.
module tb_branch_unit;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, JZ = 3'd2, JNZ = 3'd3,
                         JC = 3'd4, JB = 3'd5, CALL = 3'd6, RET = 3'd7;

  logic              clk = 1'b0;
  logic              br_rst_n;
  logic              br_en;
  logic [2:0]        br_op;
  logic [ADDR_W-1:0] br_target;
  logic              br_flag_c, br_flag_z, br_flag_b;
  logic [ADDR_W-1:0] br_pc;
  logic              br_taken;
  logic [2:0]        br_sp;
  logic              br_err;

  typedef struct {
    logic [7:0] pc;
    logic       taken;
    int         sp;
    logic       err;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m_pc;
  int         m_sp;
  logic       m_err;
  logic [7:0] m_stack [DEPTH];
  int         total = 0;
  int         bad   = 0;

  branch_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .br_rst_n  (br_rst_n),
    .br_en     (br_en),
    .br_op     (br_op),
    .br_target (br_target),
    .br_flag_c (br_flag_c),
    .br_flag_z (br_flag_z),
    .br_flag_b (br_flag_b),
    .br_pc     (br_pc),
    .br_taken  (br_taken),
    .br_sp     (br_sp),
    .br_err    (br_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_sp = 0; m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_stack[i] = 8'h00;
  endtask

  // Drive one cycle at the falling edge, predict, then compare after the rising edge.
  task automatic step(input logic en, input logic [2:0] op, input logic [7:0] tgt,
                      input logic c, input logic z, input logic b);
    exp_t       e;
    logic [7:0] seq;
    logic       hit;
    @(negedge clk);
    br_en = en; br_op = op; br_target = tgt;
    br_flag_c = c; br_flag_z = z; br_flag_b = b;
    seq = m_pc + 8'd1;
    e.taken = 1'b0;
    if (en) begin
      hit = (op == JMP) || (op == JZ && z) || (op == JNZ && !z) ||
            (op == JC && c) || (op == JB && b);
      if (op == CALL) begin
        if (m_sp < DEPTH) begin
          m_stack[m_sp] = seq; m_sp = m_sp + 1; m_pc = tgt; e.taken = 1'b1;
        end else begin
          m_err = 1'b1; m_pc = seq;
        end
      end else if (op == RET) begin
        if (m_sp > 0) begin
          m_sp = m_sp - 1; m_pc = m_stack[m_sp]; e.taken = 1'b1;
        end else begin
          m_err = 1'b1; m_pc = seq;
        end
      end else if (hit) begin
        m_pc = tgt; e.taken = 1'b1;
      end else begin
        m_pc = seq;
      end
    end
    e.pc = m_pc; e.sp = m_sp; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pc", int'(br_pc), int'(e.pc));
    check("taken", int'(br_taken), int'(e.taken));
    check("sp", int'(br_sp), e.sp);
    check("err", int'(br_err), int'(e.err));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, int'(br_pc), 0);
    check({tag, "_sp"}, int'(br_sp), 0);
    check({tag, "_taken"}, int'(br_taken), 0);
    check({tag, "_err"}, int'(br_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    br_rst_n = 1'b0; br_en = 1'b0; br_op = NOP; br_target = '0;
    br_flag_c = 1'b0; br_flag_z = 1'b0; br_flag_b = 1'b0;
    model_reset();
    #1 check_reset_state("por");
    repeat (2) @(negedge clk);
    br_rst_n = 1'b1;

    // Sequential fetch then stall.
    repeat (3) step(1, NOP, 8'hAA, 1, 1, 1);
    check("pc_after_3_nops", int'(br_pc), 3);
    repeat (2) step(0, JMP, 8'h77, 0, 0, 0);
    check("pc_held_in_stall", int'(br_pc), 3);

    // Conditional jumps, each with the flag false then true, from pc=0x10.
    for (int k = 0; k < 4; k++) begin
      logic [2:0] op;
      op = JZ + 3'(k);
      step(1, JMP, 8'h10, 0, 0, 0);
      step(1, op, 8'h40, (op == JC) ? 1'b0 : 1'b1, (op == JNZ) ? 1'b1 : 1'b0, 1'b0);
      check("cond_false_pc", int'(br_pc), 'h11);
      step(1, JMP, 8'h10, 0, 0, 0);
      step(1, op, 8'h40, (op == JC), (op == JZ), (op == JB));
      check("cond_true_pc", int'(br_pc), 'h40);
    end

    // PC wrap, and CALL from 0xFF returning to the wrapped address.
    step(1, JMP, 8'hFF, 0, 0, 0);
    step(1, NOP, 8'h00, 0, 0, 0);
    check("wrap_pc", int'(br_pc), 0);
    step(1, JMP, 8'hFF, 0, 0, 0);
    step(1, CALL, 8'h20, 0, 0, 0);
    step(1, RET, 8'h99, 1, 1, 1);
    check("ret_wrap_pc", int'(br_pc), 0);

    // Nested CALL/RET.
    step(1, JMP, 8'h05, 0, 0, 0);
    step(1, CALL, 8'h30, 0, 0, 0);
    step(1, CALL, 8'h50, 0, 0, 0);
    step(1, RET, 8'h00, 0, 0, 0);
    check("nest_ret1_pc", int'(br_pc), 'h31);
    step(1, RET, 8'h00, 0, 0, 0);
    check("nest_ret2_pc", int'(br_pc), 'h06);
    check("nest_err", int'(br_err), 0);

    // CALL to pc+1, then overflow and underflow.
    step(1, CALL, br_pc + 8'd1, 0, 0, 0);
    step(1, RET, 8'h00, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(1, CALL, 8'(8'h60 + 8'(k * 16)), 0, 0, 0);
    check("ovf_sp", int'(br_sp), 4);
    check("ovf_err", int'(br_err), 1);
    for (int k = 0; k < 5; k++) step(1, RET, 8'h00, 0, 0, 0);
    check("udf_sp", int'(br_sp), 0);

    // Asynchronous reset between edges with two entries on the stack.
    begin
      logic [7:0] at_rst;
      step(1, CALL, 8'h12, 0, 0, 0);
      step(1, CALL, 8'h34, 0, 0, 0);
      check("pre_rst_sp", int'(br_sp), 2);
      at_rst = br_pc;
      @(negedge clk);
      br_en = 1'b0;
      #2 br_rst_n = 1'b0;
      #1 check_reset_state("async");
      check("async_pc_changed", int'(at_rst != br_pc), 1);
      #1 br_rst_n = 1'b1;
      model_reset();
    end
    step(1, RET, 8'h00, 0, 0, 0);
    check("post_rst_udf_err", int'(br_err), 1);
    check("post_rst_udf_pc", int'(br_pc), 1);

    // Random mix against the model.
    for (int k = 0; k < 60; k++)
      step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
